// File: rtl/pad_cfg_ctrl.sv
// Pad-ring electrical control register block: shadow config written over a simple bus,
// committed to the active vectors by a one-pad-per-cycle sweep. Optional LOCK register: PAD_CFG_LOCK_EN.
module pad_cfg_ctrl #(
  parameter int         NUM_PAD     = 10,
  parameter int         HOLD_CYCLES = 16,
  parameter logic [5:0] DEFAULT_CFG = 6'b000001
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [7:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ack,
  output logic [NUM_PAD-1:0] control_DS0,
  output logic [NUM_PAD-1:0] control_DS1,
  output logic [NUM_PAD-1:0] control_PE,
  output logic [NUM_PAD-1:0] control_PS,
  output logic [NUM_PAD-1:0] control_IS,
  output logic [NUM_PAD-1:0] control_SR,
  output logic               pad_hold,
  output logic               busy
);

  localparam int IW = (NUM_PAD > 1) ? $clog2(NUM_PAD) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_PAD - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0] ADDR_COMMIT = 8'h80;
  localparam logic [7:0] ADDR_STATUS = 8'h81;
  localparam logic [7:0] ADDR_LOCK   = 8'h82;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idx;
  logic          pending;
  logic          lock;
  logic          sweep_en;
  logic          sweep_start;
  logic          wr_en;
  logic          cfg_wr_ok;
  logic          commit_wr;
  logic [31:0]   rd_val;
  logic [5:0]    shadow [NUM_PAD];
  logic [5:0]    active [NUM_PAD];
  logic          unused_wdata;

  assign unused_wdata = &{1'b0, wdata[31:6]};

  assign wr_en     = req & we;
  assign cfg_wr_ok = wr_en & ~lock;
  assign commit_wr = cfg_wr_ok & (addr == ADDR_COMMIT) & wdata[0];

`ifdef PAD_CFG_LOCK_EN
  // Lock is sticky: only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      lock <= 1'b0;
    else if (wr_en && addr == ADDR_LOCK && wdata[0])
      lock <= 1'b1;
  end
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_HOLD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:  if (hold_cnt == LAST_HOLD) state_nxt = ST_IDLE;
      ST_IDLE:  if (pending) state_nxt = ST_SWEEP;
      ST_SWEEP: if (idx == LAST_IDX) state_nxt = ST_IDLE;
      default:  state_nxt = ST_HOLD;
    endcase
  end

  always_comb begin
    pad_hold    = (state == ST_HOLD);
    sweep_en    = (state == ST_SWEEP);
    sweep_start = (state == ST_IDLE) & pending;
    busy        = (state != ST_IDLE) | pending;
  end

  // A commit write in the same cycle the FSM consumes pending wins, queueing one more sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      idx      <= '0;
      pending  <= 1'b0;
    end else begin
      if (state == ST_HOLD && hold_cnt != LAST_HOLD)
        hold_cnt <= hold_cnt + 1'b1;
      if (sweep_start)
        idx <= '0;
      else if (sweep_en)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (commit_wr)
        pending <= 1'b1;
      else if (sweep_start)
        pending <= 1'b0;
    end
  end

  // Sweep copies the pre-edge shadow, so a same-cycle write to the visited pad waits for the next commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PAD; i++) begin
        shadow[i] <= DEFAULT_CFG;
        active[i] <= DEFAULT_CFG;
      end
    end else begin
      for (int i = 0; i < NUM_PAD; i++) begin
        if (cfg_wr_ok && addr == 8'(i))
          shadow[i] <= wdata[5:0];
        if (sweep_en && idx == IW'(i))
          active[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_PAD; i++) begin
      if (addr == 8'(i))
        rd_val[5:0] = shadow[i];
    end
    if (addr == ADDR_STATUS)
      rd_val = {29'b0, lock, pending, busy};
`ifdef PAD_CFG_LOCK_EN
    if (addr == ADDR_LOCK)
      rd_val = {31'b0, lock};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= (req && !we) ? rd_val : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PAD; i++) begin
      control_DS0[i] = active[i][0];
      control_DS1[i] = active[i][1];
      control_PE[i]  = active[i][2];
      control_PS[i]  = active[i][3];
      control_IS[i]  = active[i][4];
      control_SR[i]  = active[i][5];
    end
  end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed self-checking bench for pad_cfg_ctrl (NUM_PAD=10, HOLD_CYCLES=16, DEFAULT_CFG=1).
module tb_pad_cfg_ctrl;

  localparam int NUM_PAD     = 10;
  localparam int HOLD_CYCLES = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req;
  logic               we;
  logic [7:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ack;
  logic [NUM_PAD-1:0] control_DS0, control_DS1, control_PE, control_PS, control_IS, control_SR;
  logic               pad_hold;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  always #5 clk = ~clk;

  pad_cfg_ctrl #(
    .NUM_PAD    (NUM_PAD),
    .HOLD_CYCLES(HOLD_CYCLES),
    .DEFAULT_CFG(6'b000001)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ack        (ack),
    .control_DS0(control_DS0),
    .control_DS1(control_DS1),
    .control_PE (control_PE),
    .control_PS (control_PS),
    .control_IS (control_IS),
    .control_SR (control_SR),
    .pad_hold   (pad_hold),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input string tag);
    req   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    req = 1'b0;
    we  = 1'b0;
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    req  = 1'b1;
    we   = 1'b0;
    addr = a;
    tick();
    req = 1'b0;
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic chk_vec(input string tag, input logic [NUM_PAD-1:0] ds0, input logic [NUM_PAD-1:0] ds1,
                         input logic [NUM_PAD-1:0] pe, input logic [NUM_PAD-1:0] ps,
                         input logic [NUM_PAD-1:0] is_v, input logic [NUM_PAD-1:0] sr);
    chk({tag, "_ds0"}, 32'(control_DS0), 32'(ds0));
    chk({tag, "_ds1"}, 32'(control_DS1), 32'(ds1));
    chk({tag, "_pe"},  32'(control_PE),  32'(pe));
    chk({tag, "_ps"},  32'(control_PS),  32'(ps));
    chk({tag, "_is"},  32'(control_IS),  32'(is_v));
    chk({tag, "_sr"},  32'(control_SR),  32'(sr));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 8'h00;
    wdata = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_pad_hold", {31'b0, pad_hold}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk_vec("rst", 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);

    // Hold length after release
    rst_n = 1'b1;
    n = 0;
    while (pad_hold && n < 40) begin
      n++;
      tick();
    end
    chk("hold_len", n, 32'd16);
    chk("hold_busy_drop", {31'b0, busy}, 32'd0);

    // Register access basics
    bus_read(8'h81, 32'h0, "status_idle");
    tick();
    chk("ack_idle", {31'b0, ack}, 32'd0);
    chk("rdata_idle", rdata, 32'd0);
    bus_read(8'h03, 32'h01, "shadow3_default");
    bus_write(8'h03, 32'hABCD_EF26, "wr_shadow3");
    chk("wr_rdata_zero", rdata, 32'd0);
    bus_read(8'h03, 32'h26, "shadow3_readback");
    bus_read(8'h40, 32'h0, "unmapped_40");
    chk_vec("no_commit", 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);

    // First commit: pad 3 updates on the fourth sweep edge, busy for 11 cycles total
    bus_write(8'h80, 32'h1, "commit1");
    chk("commit1_busy", {31'b0, busy}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("pre_visit3_ds1", 32'(control_DS1), 32'h000);
    tick();
    chk_vec("visit3", 10'h3F7, 10'h008, 10'h008, 10'h000, 10'h000, 10'h008);
    chk("visit3_busy", {31'b0, busy}, 32'd1);
    n = 5;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("sweep1_len", n, 32'd11);

    // Writes during a sweep at idx=5 plus a second commit
    bus_write(8'h80, 32'h1, "commit2");
    tick(); tick(); tick(); tick(); tick(); tick();
    bus_write(8'h08, 32'h3F, "wr_shadow8");
    bus_write(8'h02, 32'h3F, "wr_shadow2");
    bus_write(8'h80, 32'h1, "commit3");
    tick();
    chk("pad8_first_sweep_pe", 32'(control_PE), 32'h108);
    tick();
    chk("between_sweeps_busy", {31'b0, busy}, 32'd1);
    tick(); tick(); tick();
    chk("pad2_not_yet_pe", 32'(control_PE), 32'h108);
    tick();
    chk("pad2_second_sweep_pe", 32'(control_PE), 32'h10C);
    n = 15;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("two_sweeps_len", n, 32'd22);
    tick(); tick(); tick();
    chk("no_third_sweep", {31'b0, busy}, 32'd0);
    chk_vec("after_two", 10'h3F7, 10'h10C, 10'h10C, 10'h104, 10'h104, 10'h10C);

    // Reset while sweeping at idx=4 with a further commit pending
    bus_write(8'h80, 32'h1, "commit4");
    tick(); tick();
    bus_write(8'h80, 32'h1, "commit5");
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk_vec("midsweep_rst", 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    chk("midsweep_rst_hold", {31'b0, pad_hold}, 32'd1);
    chk("midsweep_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b1;
    bus_read(8'h81, 32'h1, "status_after_rst");
    bus_read(8'h02, 32'h01, "shadow2_after_rst");

    // Commit during hold: pending visible, sweep begins the cycle after hold drops
    bus_write(8'h00, 32'h3E, "wr_shadow0_hold");
    bus_write(8'h80, 32'h1, "commit_hold");
    bus_read(8'h81, 32'h3, "status_pending");
    n = 0;
    while (pad_hold && n < 40) begin
      tick();
      n++;
    end
    chk("hold_drop", {31'b0, pad_hold}, 32'd0);
    chk("hold_drop_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("sweep_start_ds0", 32'(control_DS0), 32'h3FF);
    tick();
    chk("pad0_visit_ds0", 32'(control_DS0), 32'h3FE);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("hold_sweep_rest", n, 32'd9);

`ifdef PAD_CFG_LOCK_EN
    bus_write(8'h82, 32'h1, "wr_lock");
    bus_read(8'h82, 32'h1, "lock_read");
    bus_write(8'h00, 32'h3F, "wr_shadow0_locked");
    bus_write(8'h80, 32'h1, "commit_locked");
    bus_read(8'h00, 32'h3E, "shadow0_locked");
    bus_read(8'h81, 32'h4, "status_locked");
    chk("locked_no_sweep", {31'b0, busy}, 32'd0);
    chk("locked_ds0", 32'(control_DS0), 32'h3FE);
`else
    bus_write(8'h82, 32'h1, "wr_82_unmapped");
    bus_read(8'h82, 32'h0, "read_82_unmapped");
    bus_write(8'h00, 32'h3F, "wr_shadow0_unlocked");
    bus_read(8'h00, 32'h3F, "shadow0_unlocked");
    bus_read(8'h81, 32'h0, "status_no_lock");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
